peak_counter_stream: RTL

//  Parametrised successor to the peak-counter datapath: NUM_CH edge counters with selectable wrap or saturate

---
 rtl/peak_counter_stream.sv | 123 ++++++++++++
 1 files changed

// File: rtl/peak_counter_stream.sv
// Multi-channel edge counters with snapshot shadow bank.
// Frames of count words plus sticky-overflow words leave on a valid/ready stream.
module peak_counter_stream #(
  parameter int NUM_CH     = 24,
  parameter int CNTR_WIDTH = 8,
  parameter int SATURATE   = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_CH-1:0]     sig_in,
  input  logic                  count_en,
  input  logic                  snap,
  output logic [CNTR_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  busy,
  output logic                  snap_drop
);

  localparam int OVF_WORDS = (NUM_CH + CNTR_WIDTH - 1) / CNTR_WIDTH;
  localparam int FRAME_LEN = NUM_CH + OVF_WORDS;
  localparam int IW        = $clog2(FRAME_LEN);
  localparam logic [IW-1:0] LAST = IW'(FRAME_LEN - 1);
  localparam logic [CNTR_WIDTH-1:0] MAX = '1;

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] STREAM = 1'b1;

  logic [0:0]                       state;
  logic [IW-1:0]                    idx;
  logic [NUM_CH-1:0]                prev;
  logic [NUM_CH-1:0]                hit;
  logic [NUM_CH-1:0]                ovf;
  logic [NUM_CH-1:0]                shadow_ovf;
  logic [NUM_CH-1:0][CNTR_WIDTH-1:0] cnt;
  logic [NUM_CH-1:0][CNTR_WIDTH-1:0] shadow;
  logic [OVF_WORDS*CNTR_WIDTH-1:0]  ovf_pad;
  logic [CNTR_WIDTH-1:0]            frame_w [FRAME_LEN];
  logic [CNTR_WIDTH-1:0]            nxt_word;
  logic                             hs;
  logic                             at_last;
  logic                             snap_ok;

  assign hit       = sig_in & ~prev & {NUM_CH{count_en}};
  assign out_valid = (state == STREAM);
  assign busy      = (state == STREAM);
  assign at_last   = (idx == LAST);
  assign out_last  = out_valid & at_last;
  assign hs        = out_valid & out_ready;
  // A snap on the closing handshake chains straight into the next frame.
  assign snap_ok   = snap & (~out_valid | (hs & at_last));

  always_comb begin
    ovf_pad = '0;
    ovf_pad[NUM_CH-1:0] = shadow_ovf;
    for (int j = 0; j < NUM_CH; j++) begin
      frame_w[j] = shadow[j];
    end
    for (int k = 0; k < OVF_WORDS; k++) begin
      frame_w[NUM_CH+k] = ovf_pad[k*CNTR_WIDTH +: CNTR_WIDTH];
    end
    nxt_word = '0;
    for (int j = 1; j < FRAME_LEN; j++) begin
      if (idx == IW'(j - 1)) nxt_word = frame_w[j];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev       <= '0;
      cnt        <= '0;
      ovf        <= '0;
      shadow     <= '0;
      shadow_ovf <= '0;
    end else begin
      prev <= sig_in;
      if (snap_ok) begin
        shadow     <= cnt;
        shadow_ovf <= ovf;
        ovf        <= '0;
      end
      for (int i = 0; i < NUM_CH; i++) begin
        if (snap_ok) begin
          cnt[i] <= CNTR_WIDTH'(hit[i]);
        end else if (hit[i]) begin
          if (cnt[i] == MAX) begin
            cnt[i] <= (SATURATE != 0) ? MAX : '0;
            ovf[i] <= 1'b1;
          end else begin
            cnt[i] <= cnt[i] + 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      out_data  <= '0;
      snap_drop <= 1'b0;
    end else begin
      snap_drop <= snap & ~snap_ok;
      if (snap_ok) begin
        state    <= STREAM;
        idx      <= '0;
        out_data <= cnt[0];
      end else if (hs) begin
        if (at_last) begin
          state    <= IDLE;
          idx      <= '0;
          out_data <= '0;
        end else begin
          idx      <= idx + 1'b1;
          out_data <= nxt_word;
        end
      end
    end
  end

endmodule
